// File: rtl/sc_alu_iter.sv
// rtl/sc_alu_iter.sv - 32-bit integer execution unit with N/Z/V/C codes and status-register write strobe
// Define SC_ALUITER_MUL_EN to build the 32-cycle shift-add UMULCC path; otherwise opcode E acts as reserved.
module sc_alu_iter (
  input  logic        SC_AluIter_CLOCK_50,
  input  logic        SC_AluIter_RESET_InLow,
  input  logic        SC_AluIter_Start,
  input  logic [3:0]  SC_AluIter_Op,
  input  logic [31:0] SC_AluIter_A,
  input  logic [31:0] SC_AluIter_B,
  input  logic        SC_AluIter_carry_In,
  output logic [31:0] SC_AluIter_Result,
  output logic [31:0] SC_AluIter_ResultHi,
  output logic        SC_AluIter_negativo,
  output logic        SC_AluIter_cero,
  output logic        SC_AluIter_overflow,
  output logic        SC_AluIter_carry,
  output logic        SC_AluIter_PsrWrite_OutLow,
  output logic        SC_AluIter_Done,
  output logic        SC_AluIter_Busy
);
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ADDCC = 4'h1;
  localparam logic [3:0] OP_ADDX  = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_SUBCC = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_ANDCC = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_ORCC  = 4'h8;
  localparam logic [3:0] OP_XOR   = 4'h9;
  localparam logic [3:0] OP_XORCC = 4'hA;
  localparam logic [3:0] OP_SLL   = 4'hB;
  localparam logic [3:0] OP_SRL   = 4'hC;
  localparam logic [3:0] OP_SRA   = 4'hD;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;
  state_t state;

  logic [32:0] add_sum;
  logic [32:0] sub_dif;
  logic [31:0] alu_res;
  logic        alu_cc;
  logic        alu_v;
  logic        alu_c;

  always_comb begin
    add_sum = {1'b0, SC_AluIter_A} + {1'b0, SC_AluIter_B}
            + {32'd0, (SC_AluIter_Op == OP_ADDX) & SC_AluIter_carry_In};
    sub_dif = {1'b0, SC_AluIter_A} - {1'b0, SC_AluIter_B};
    alu_res = 32'd0;
    alu_cc  = 1'b0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (SC_AluIter_Op)
      OP_ADD:   alu_res = add_sum[31:0];
      OP_ADDCC, OP_ADDX: begin
        alu_res = add_sum[31:0];
        alu_cc  = 1'b1;
        alu_v   = (SC_AluIter_A[31] == SC_AluIter_B[31]) && (add_sum[31] != SC_AluIter_A[31]);
        alu_c   = add_sum[32];
      end
      OP_SUB:   alu_res = sub_dif[31:0];
      OP_SUBCC: begin
        alu_res = sub_dif[31:0];
        alu_cc  = 1'b1;
        alu_v   = (SC_AluIter_A[31] != SC_AluIter_B[31]) && (sub_dif[31] != SC_AluIter_A[31]);
        alu_c   = sub_dif[32];  // borrow: A < B unsigned
      end
      OP_AND:   alu_res = SC_AluIter_A & SC_AluIter_B;
      OP_ANDCC: begin alu_res = SC_AluIter_A & SC_AluIter_B; alu_cc = 1'b1; end
      OP_OR:    alu_res = SC_AluIter_A | SC_AluIter_B;
      OP_ORCC:  begin alu_res = SC_AluIter_A | SC_AluIter_B; alu_cc = 1'b1; end
      OP_XOR:   alu_res = SC_AluIter_A ^ SC_AluIter_B;
      OP_XORCC: begin alu_res = SC_AluIter_A ^ SC_AluIter_B; alu_cc = 1'b1; end
      OP_SLL:   alu_res = SC_AluIter_A << SC_AluIter_B[4:0];
      OP_SRL:   alu_res = SC_AluIter_A >> SC_AluIter_B[4:0];
      OP_SRA:   alu_res = $unsigned($signed(SC_AluIter_A) >>> SC_AluIter_B[4:0]);
      default:  alu_res = 32'd0;
    endcase
  end

`ifdef SC_ALUITER_MUL_EN
  localparam logic [3:0] OP_UMULCC = 4'hE;

  logic [63:0] mul_acc;
  logic [31:0] mul_a;
  logic [4:0]  mul_cnt;
  logic [32:0] mul_psum;
  logic [63:0] mul_next;

  // Upper word accumulates the multiplicand; lower word shifts out multiplier bits LSB first.
  always_comb begin
    mul_psum = {1'b0, mul_acc[63:32]} + (mul_acc[0] ? {1'b0, mul_a} : 33'd0);
    mul_next = {mul_psum, mul_acc[31:1]};
  end
`else
  assign SC_AluIter_Busy = 1'b0;
`endif

  always_ff @(posedge SC_AluIter_CLOCK_50 or negedge SC_AluIter_RESET_InLow) begin
    if (!SC_AluIter_RESET_InLow) begin
      state                      <= IDLE;
      SC_AluIter_Result          <= 32'd0;
      SC_AluIter_ResultHi        <= 32'd0;
      SC_AluIter_negativo        <= 1'b0;
      SC_AluIter_cero            <= 1'b0;
      SC_AluIter_overflow        <= 1'b0;
      SC_AluIter_carry           <= 1'b0;
      SC_AluIter_PsrWrite_OutLow <= 1'b1;
      SC_AluIter_Done            <= 1'b0;
`ifdef SC_ALUITER_MUL_EN
      SC_AluIter_Busy            <= 1'b0;
      mul_acc                    <= 64'd0;
      mul_a                      <= 32'd0;
      mul_cnt                    <= 5'd0;
`endif
    end else begin
      SC_AluIter_Done            <= 1'b0;
      SC_AluIter_PsrWrite_OutLow <= 1'b1;
      case (state)
`ifdef SC_ALUITER_MUL_EN
        MUL: begin
          mul_acc <= mul_next;
          mul_cnt <= mul_cnt + 5'd1;
          if (mul_cnt == 5'd31) begin
            state                      <= DONE;
            SC_AluIter_Busy            <= 1'b0;
            SC_AluIter_Done            <= 1'b1;
            SC_AluIter_PsrWrite_OutLow <= 1'b0;
            SC_AluIter_Result          <= mul_next[31:0];
            SC_AluIter_ResultHi        <= mul_next[63:32];
            SC_AluIter_negativo        <= mul_next[31];
            SC_AluIter_cero            <= (mul_next[31:0] == 32'd0);
            SC_AluIter_overflow        <= 1'b0;
            SC_AluIter_carry           <= 1'b0;
          end
        end
`endif
        default: begin
          if (SC_AluIter_Start) begin
`ifdef SC_ALUITER_MUL_EN
            if (SC_AluIter_Op == OP_UMULCC) begin
              state           <= MUL;
              SC_AluIter_Busy <= 1'b1;
              mul_cnt         <= 5'd0;
              mul_acc         <= {32'd0, SC_AluIter_B};
              mul_a           <= SC_AluIter_A;
            end else
`endif
            begin
              state               <= DONE;
              SC_AluIter_Done     <= 1'b1;
              SC_AluIter_Result   <= alu_res;
              SC_AluIter_ResultHi <= 32'd0;
              if (alu_cc) begin
                SC_AluIter_PsrWrite_OutLow <= 1'b0;
                SC_AluIter_negativo        <= alu_res[31];
                SC_AluIter_cero            <= (alu_res == 32'd0);
                SC_AluIter_overflow        <= alu_v;
                SC_AluIter_carry           <= alu_c;
              end
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sc_alu_iter.sv
// tb/tb_sc_alu_iter.sv - self-checking bench for sc_alu_iter against a behavioural model
// Follows SC_ALUITER_MUL_EN to choose multiply or reserved behaviour for opcode E.
module tb_sc_alu_iter;
`ifdef SC_ALUITER_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        ci = 1'b0;
  logic [31:0] result, result_hi;
  logic        f_n, f_z, f_v, f_c, psr_n, done, busy;

  int checks = 0;
  int errors = 0;

  sc_alu_iter dut (
    .SC_AluIter_CLOCK_50       (clk),
    .SC_AluIter_RESET_InLow    (rst_n),
    .SC_AluIter_Start          (start),
    .SC_AluIter_Op             (op),
    .SC_AluIter_A              (a),
    .SC_AluIter_B              (b),
    .SC_AluIter_carry_In       (ci),
    .SC_AluIter_Result         (result),
    .SC_AluIter_ResultHi       (result_hi),
    .SC_AluIter_negativo       (f_n),
    .SC_AluIter_cero           (f_z),
    .SC_AluIter_overflow       (f_v),
    .SC_AluIter_carry          (f_c),
    .SC_AluIter_PsrWrite_OutLow(psr_n),
    .SC_AluIter_Done           (done),
    .SC_AluIter_Busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: expected outputs after each rising edge.
  logic [31:0] m_result = 32'd0, m_hi = 32'd0;
  logic        m_n = 1'b0, m_z = 1'b0, m_v = 1'b0, m_c = 1'b0;
  logic        m_psr = 1'b1, m_done = 1'b0, m_busy = 1'b0;
  logic        m_pend = 1'b0, m_valid = 1'b0;
  int          m_left = 0;
  logic [63:0] m_prod = 64'd0;

  always @(posedge clk) begin : model
    logic [31:0] r;
    logic        cc, v, c;
    logic [63:0] wide;
    longint      sa, sb, sr;
    int          cin;
    if (!rst_n) begin
      m_result = 32'd0; m_hi = 32'd0;
      m_n = 1'b0; m_z = 1'b0; m_v = 1'b0; m_c = 1'b0;
      m_psr = 1'b1; m_done = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
    end else begin
      m_done = 1'b0;
      m_psr  = 1'b1;
      if (m_pend) begin
        m_left--;
        if (m_left == 0) begin
          m_pend = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_psr = 1'b0;
          m_result = m_prod[31:0]; m_hi = m_prod[63:32];
          m_n = m_prod[31]; m_z = (m_prod[31:0] == 32'd0); m_v = 1'b0; m_c = 1'b0;
        end
      end else if (start) begin
        if (MUL_EN && op == 4'hE) begin
          m_pend = 1'b1; m_left = 32; m_busy = 1'b1;
          m_prod = {32'd0, a} * {32'd0, b};
        end else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          cin = (op == 4'h2 && ci) ? 1 : 0;
          r = 32'd0; cc = 1'b0; v = 1'b0; c = 1'b0;
          case (op)
            4'h0, 4'h1, 4'h2: begin
              wide = {32'd0, a} + {32'd0, b} + 64'(cin);
              r = wide[31:0]; c = wide[32]; cc = (op != 4'h0);
              sr = sa + sb + longint'(cin);
              v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'h3, 4'h4: begin
              r = a - b; c = (a < b); cc = (op == 4'h4);
              sr = sa - sb;
              v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'h5, 4'h6: begin r = a & b; cc = (op == 4'h6); end
            4'h7, 4'h8: begin r = a | b; cc = (op == 4'h8); end
            4'h9, 4'hA: begin r = a ^ b; cc = (op == 4'hA); end
            4'hB: r = a << b[4:0];
            4'hC: r = a >> b[4:0];
            4'hD: r = $unsigned($signed(a) >>> b[4:0]);
            default: r = 32'd0;
          endcase
          m_done = 1'b1; m_result = r; m_hi = 32'd0;
          if (cc) begin
            m_psr = 1'b0;
            m_n = r[31]; m_z = (r == 32'd0); m_v = v; m_c = c;
          end
        end
      end
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("result", 64'(result), 64'(m_result));
      chk("result_hi", 64'(result_hi), 64'(m_hi));
      chk("flags_nzvc", 64'({f_n, f_z, f_v, f_c}), 64'({m_n, m_z, m_v, m_c}));
      chk("psr_write_n", 64'(psr_n), 64'(m_psr));
      chk("done", 64'(done), 64'(m_done));
      chk("busy", 64'(busy), 64'(m_busy));
    end
  end

  task automatic issue(input logic s, input logic [3:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic c);
    #1;
    start = s; op = o; a = aa; b = bb; ci = c;
  endtask

  task automatic lit_out(input string nm, input logic [31:0] r, input logic [3:0] fl,
                         input logic d, input logic p);
    chk({nm, "_result"}, 64'(result), 64'(r));
    chk({nm, "_flags"}, 64'({f_n, f_z, f_v, f_c}), 64'(fl));
    chk({nm, "_done"}, 64'(done), 64'(d));
    chk({nm, "_psr"}, 64'(psr_n), 64'(p));
    chk({nm, "_model_result"}, 64'(m_result), 64'(r));
    chk({nm, "_model_flags"}, 64'({m_n, m_z, m_v, m_c}), 64'(fl));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    lit_out("reset", 32'd0, 4'b0000, 1'b0, 1'b1);
    chk("reset_hi", 64'(result_hi), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    #1 rst_n = 1'b1;
    issue(1'b1, 4'h1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    @(negedge clk);
    lit_out("addcc_ovf", 32'h8000_0000, 4'b1010, 1'b1, 1'b0);
    issue(1'b1, 4'h4, 32'd5, 32'd5, 1'b0);
    @(negedge clk);
    lit_out("subcc_zero", 32'd0, 4'b0100, 1'b1, 1'b0);
    issue(1'b1, 4'h4, 32'd3, 32'd5, 1'b0);
    @(negedge clk);
    lit_out("subcc_borrow", 32'hFFFF_FFFE, 4'b1001, 1'b1, 1'b0);
    issue(1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    lit_out("idle_after", 32'hFFFF_FFFE, 4'b1001, 1'b0, 1'b1);
    issue(1'b1, 4'h2, 32'hFFFF_FFFF, 32'd0, 1'b1);
    @(negedge clk);
    lit_out("addx_carry", 32'd0, 4'b0101, 1'b1, 1'b0);
    issue(1'b1, 4'h0, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    lit_out("add_nocc", 32'd7, 4'b0101, 1'b1, 1'b1);
    issue(1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
`ifdef SC_ALUITER_MUL_EN
    issue(1'b1, 4'hE, 32'hFFFF_FFFF, 32'd2, 1'b0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("mul_busy", 64'(busy), 64'd1);
      chk("mul_no_done", 64'(done), 64'd0);
      if (i == 3) issue(1'b1, 4'h6, 32'h0, 32'h0, 1'b0);
      else issue(1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
    end
    @(negedge clk);
    lit_out("umulcc", 32'hFFFF_FFFE, 4'b1000, 1'b1, 1'b0);
    chk("umulcc_hi", 64'(result_hi), 64'h1);
    chk("umulcc_busy", 64'(busy), 64'd0);
    issue(1'b0, 4'h0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    issue(1'b1, 4'hE, $urandom, $urandom, 1'b0);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0; start = 1'b0;
    @(negedge clk);
    lit_out("mul_abort", 32'd0, 4'b0000, 1'b0, 1'b1);
    chk("mul_abort_busy", 64'(busy), 64'd0);
    chk("mul_abort_hi", 64'(result_hi), 64'd0);
    #1 rst_n = 1'b1;
`else
    issue(1'b1, 4'hE, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    @(negedge clk);
    lit_out("op_e_reserved", 32'd0, 4'b0101, 1'b1, 1'b1);
    chk("op_e_busy", 64'(busy), 64'd0);
`endif
    issue(1'b1, 4'hB, 32'd1, 32'd4, 1'b0);
    @(negedge clk);
    lit_out("sll", 32'h10, {m_n, m_z, m_v, m_c}, 1'b1, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      #1;
      rst_n = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 3) != 0);
      op    = 4'($urandom_range(0, 15));
      a     = pick();
      b     = pick();
      ci    = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    #1 rst_n = 1'b1; start = 1'b0;
    repeat (40) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
